// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 VGA timing constants, counter types and decode helpers.
// No logic of its own; no latency or flow control.
// Imported by the sync generator and the sprite display.
package vga_sync_gen_pkg;

    localparam int VGA_CNT_W       = 10;
    localparam int VGA_FRAME_CNT_W = 8;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

    // True when pos lies in the half-open window [first, past_last).
    function automatic logic in_window(vga_cnt_t pos, vga_cnt_t first, vga_cnt_t past_last);
        return (pos >= first) && (pos < past_last);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Shift register that delays sync bits to line up with a pipelined colour path.
// Latency: DEPTH enabled clocks (DEPTH = 0 is a wire).
// Backpressure: none; stages only advance when enable is high, resetting to all ones.
module sync_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             enable,
    input  logic [WIDTH-1:0] sync_dat,
    output logic [WIDTH-1:0] delayed_dat
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{i_Clk, i_Rst_L, enable};
            assign delayed_dat = sync_dat;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '1;
                    end
                end else if (enable) begin
                    stage[0] <= sync_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign delayed_dat = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, visible flag, syncs, frame pulse and count.
// Latency: all outputs registered; syncs/visible match the counters, *_D lag by SYNC_DELAY.
// Backpressure: i_Enable low freezes all timing state and forces o_Frame_Start low.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int H_VISIBLE_AREA = VGA_H_VISIBLE,
    parameter int H_FRONT_PORCH  = VGA_H_FRONT,
    parameter int H_SYNC_PULSE   = VGA_H_SYNC,
    parameter int H_BACK_PORCH   = VGA_H_BACK,
    parameter int V_VISIBLE_AREA = VGA_V_VISIBLE,
    parameter int V_FRONT_PORCH  = VGA_V_FRONT,
    parameter int V_SYNC_PULSE   = VGA_V_SYNC,
    parameter int V_BACK_PORCH   = VGA_V_BACK,
    parameter int SYNC_DELAY     = 2
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic                       i_Enable,
    output logic [VGA_CNT_W-1:0]       o_H_Counter,
    output logic [VGA_CNT_W-1:0]       o_V_Counter,
    output logic                       o_Visible,
    output logic                       o_HSync,
    output logic                       o_VSync,
    output logic                       o_HSync_D,
    output logic                       o_VSync_D,
    output logic                       o_Frame_Start,
    output logic [VGA_FRAME_CNT_W-1:0] o_Frame_Count
);

    localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    localparam vga_cnt_t H_LAST     = vga_cnt_t'(H_TOTAL - 1);
    localparam vga_cnt_t V_LAST     = vga_cnt_t'(V_TOTAL - 1);
    localparam vga_cnt_t H_VIS      = vga_cnt_t'(H_VISIBLE_AREA);
    localparam vga_cnt_t V_VIS      = vga_cnt_t'(V_VISIBLE_AREA);
    localparam vga_cnt_t H_SYNC_ON  = vga_cnt_t'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam vga_cnt_t H_SYNC_OFF = vga_cnt_t'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam vga_cnt_t V_SYNC_ON  = vga_cnt_t'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam vga_cnt_t V_SYNC_OFF = vga_cnt_t'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

    vga_cnt_t h_next;
    vga_cnt_t v_next;
    logic     h_wrap;
    logic     v_wrap;

    always_comb begin
        h_wrap = (o_H_Counter == H_LAST);
        v_wrap = (o_V_Counter == V_LAST);
        h_next = h_wrap ? '0 : o_H_Counter + 1'b1;
        v_next = o_V_Counter;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : o_V_Counter + 1'b1;
        end
    end

    // Flags decode the next counter values so they land in the same cycle as the counters.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_H_Counter   <= '0;
            o_V_Counter   <= '0;
            o_Visible     <= 1'b0;
            o_HSync       <= 1'b1;
            o_VSync       <= 1'b1;
            o_Frame_Start <= 1'b0;
            o_Frame_Count <= '0;
        end else if (i_Enable) begin
            o_H_Counter   <= h_next;
            o_V_Counter   <= v_next;
            o_Visible     <= (h_next < H_VIS) && (v_next < V_VIS);
            o_HSync       <= !in_window(h_next, H_SYNC_ON, H_SYNC_OFF);
            o_VSync       <= !in_window(v_next, V_SYNC_ON, V_SYNC_OFF);
            o_Frame_Start <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                o_Frame_Count <= o_Frame_Count + 1'b1;
            end
        end else begin
            o_Frame_Start <= 1'b0;
        end
    end

    sync_t sync_now;
    sync_t sync_dly;

    assign sync_now.hsync = o_HSync;
    assign sync_now.vsync = o_VSync;

    sync_delay_line #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .enable      (i_Enable),
        .sync_dat    (sync_now),
        .delayed_dat (sync_dly)
    );

    assign o_HSync_D = sync_dly.hsync;
    assign o_VSync_D = sync_dly.vsync;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: raster position model derived from the count of enabled edges,
// applied to a default instance, a zero-delay instance and a shrunken-timing instance.
module tb_vga_sync_gen;

    typedef struct {
        int hv, hfp, hsp, hbp;
        int vv, vfp, vsp, vbp;
        int dly;
    } cfg_t;

    cfg_t cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    cfg_t cfg_z = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    cfg_t cfg_s = '{4, 1, 2, 1, 2, 1, 2, 1, 3};

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic cmp_on;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic [9:0] d_h, d_v, z_h, z_v, s_h, s_v;
    logic       d_vis, d_hs, d_vs, d_hsd, d_vsd, d_fs;
    logic       z_vis, z_hs, z_vs, z_hsd, z_vsd, z_fs;
    logic       s_vis, s_hs, s_vs, s_hsd, s_vsd, s_fs;
    logic [7:0] d_fc, z_fc, s_fc;

    vga_sync_gen u_dflt (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
        .o_H_Counter(d_h), .o_V_Counter(d_v), .o_Visible(d_vis),
        .o_HSync(d_hs), .o_VSync(d_vs), .o_HSync_D(d_hsd), .o_VSync_D(d_vsd),
        .o_Frame_Start(d_fs), .o_Frame_Count(d_fc)
    );

    vga_sync_gen #(.SYNC_DELAY(0)) u_bypass (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
        .o_H_Counter(z_h), .o_V_Counter(z_v), .o_Visible(z_vis),
        .o_HSync(z_hs), .o_VSync(z_vs), .o_HSync_D(z_hsd), .o_VSync_D(z_vsd),
        .o_Frame_Start(z_fs), .o_Frame_Count(z_fc)
    );

    vga_sync_gen #(
        .H_VISIBLE_AREA(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
        .V_VISIBLE_AREA(2), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .SYNC_DELAY(3)
    ) u_small (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
        .o_H_Counter(s_h), .o_V_Counter(s_v), .o_Visible(s_vis),
        .o_HSync(s_hs), .o_VSync(s_vs), .o_HSync_D(s_hsd), .o_VSync_D(s_vsd),
        .o_Frame_Start(s_fs), .o_Frame_Count(s_fc)
    );

    // Model state: number of enabled edges since reset, and whether the last edge was enabled.
    int   n;
    logic last_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n       <= 0;
            last_en <= 1'b0;
        end else begin
            last_en <= en;
            if (en) n <= n + 1;
        end
    end

    function automatic int htot(cfg_t c);
        return c.hv + c.hfp + c.hsp + c.hbp;
    endfunction

    function automatic int vtot(cfg_t c);
        return c.vv + c.vfp + c.vsp + c.vbp;
    endfunction

    function automatic logic m_hs(cfg_t c, int k);
        int h;
        if (k <= 0) return 1'b1;
        h = k % htot(c);
        return !(h >= c.hv + c.hfp && h < c.hv + c.hfp + c.hsp);
    endfunction

    function automatic logic m_vs(cfg_t c, int k);
        int v;
        if (k <= 0) return 1'b1;
        v = (k / htot(c)) % vtot(c);
        return !(v >= c.vv + c.vfp && v < c.vv + c.vfp + c.vsp);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at n=%0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input cfg_t c,
                             input logic [9:0] h, input logic [9:0] v,
                             input logic vis, input logic hs, input logic vs,
                             input logic hsd, input logic vsd, input logic fs,
                             input logic [7:0] fc);
        int fr, mh, mv;
        fr = htot(c) * vtot(c);
        mh = n % htot(c);
        mv = (n / htot(c)) % vtot(c);
        chk({tag, "_h"}, h, mh);
        chk({tag, "_v"}, v, mv);
        chk({tag, "_vis"}, vis, (n > 0 && mh < c.hv && mv < c.vv) ? 1 : 0);
        chk({tag, "_hs"}, hs, m_hs(c, n));
        chk({tag, "_vs"}, vs, m_vs(c, n));
        chk({tag, "_hsd"}, hsd, m_hs(c, n - c.dly));
        chk({tag, "_vsd"}, vsd, m_vs(c, n - c.dly));
        chk({tag, "_fs"}, fs, (last_en && n > 0 && n % fr == 0) ? 1 : 0);
        chk({tag, "_fc"}, fc, (n / fr) % 256);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check_dut("dflt", cfg_d, d_h, d_v, d_vis, d_hs, d_vs, d_hsd, d_vsd, d_fs, d_fc);
            check_dut("bypass", cfg_z, z_h, z_v, z_vis, z_hs, z_vs, z_hsd, z_vsd, z_fs, z_fc);
            check_dut("small", cfg_s, s_h, s_v, s_vis, s_hs, s_vs, s_hsd, s_vsd, s_fs, s_fc);
        end
    end

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk("run_to_position", n, target);
    endtask

    int hs_low, hs_first, hsd_first, zd_first;
    int fs_cnt, vs_low;

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        cmp_on = 1'b0;
        repeat (3) @(posedge clk);
        #2 cmp_on = 1'b1;

        @(negedge clk);
        chk("rst_h", d_h, 0);
        chk("rst_v", d_v, 0);
        chk("rst_vis", d_vis, 0);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_hsd", d_hsd, 1);
        chk("rst_fs", d_fs, 0);
        chk("rst_fc", d_fc, 0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);

        hs_low = 0; hs_first = -1; hsd_first = -1; zd_first = -1;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("first_h", d_h, 1);
                chk("first_v", d_v, 0);
                chk("first_vis", d_vis, 1);
            end
            if (i == 799) chk("line_end_h", d_h, 799);
            if (!d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(d_h);
            end
            if (!d_hsd && hsd_first < 0) hsd_first = n;
            if (!z_hsd && zd_first < 0) zd_first = n;
        end
        chk("wrap_h", d_h, 0);
        chk("wrap_v", d_v, 1);
        chk("hsync_width", hs_low, 96);
        chk("hsync_start", hs_first, 656);
        chk("hsync_d2_fall", hsd_first, 658);
        chk("hsync_d0_fall", zd_first, 656);

        run_to(1455);
        chk("pre_freeze_h", d_h, 655);
        #1 en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("freeze_h", d_h, 655);
            chk("freeze_v", d_v, 1);
            chk("freeze_hs", d_hs, 1);
            chk("freeze_fs", d_fs, 0);
        end
        #1 en = 1'b1;
        @(negedge clk);
        chk("unfreeze_h", d_h, 656);
        chk("unfreeze_hs", d_hs, 0);

        // Small instance: 8 x 6 raster, 48 clocks per frame.
        run_to(1488);
        chk("s_frame_fs", s_fs, 1);
        chk("s_frame_h", s_h, 0);
        chk("s_frame_v", s_v, 0);
        chk("s_frame_fc", s_fc, 31);
        fs_cnt = 0; vs_low = 0;
        for (int i = 1; i <= 48; i++) begin
            @(negedge clk);
            if (s_fs) fs_cnt++;
            if (!s_vs) vs_low++;
            if (i == 11) begin
                chk("s_vis_last_h", s_h, 3);
                chk("s_vis_last_v", s_v, 1);
                chk("s_vis_last", s_vis, 1);
            end
            if (i == 12) chk("s_vis_drop", s_vis, 0);
            if (i == 16) begin
                chk("s_vblank_v", s_v, 2);
                chk("s_vblank_vis", s_vis, 0);
            end
        end
        chk("s_fs_pulses", fs_cnt, 1);
        chk("s_fs_at_origin", {s_fs, s_h, s_v}, {1'b1, 20'd0});
        chk("s_fc_next", s_fc, 32);
        chk("s_vsync_width", vs_low, 16);

        run_to(12287);
        chk("s_fc_255", s_fc, 255);
        @(negedge clk);
        chk("s_fc_wrap", s_fc, 0);
        chk("s_fc_wrap_fs", s_fs, 1);

        run_to(12300);
        chk("pre_rst_h", d_h, 300);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_h", d_h, 0);
        chk("arst_v", d_v, 0);
        chk("arst_hs", d_hs, 1);
        chk("arst_vs", d_vs, 1);
        chk("arst_hsd", d_hsd, 1);
        chk("arst_vis", d_vis, 0);
        chk("arst_fc", s_fc, 0);
        @(negedge clk);
        cmp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
